// File: rtl/d_ff_reg.sv
// d_ff_reg: parameterised D-type register with complementary outputs.
//
// Adds a clock enable, synchronous clear/set (priority sclr > sset > en)
// and a one-cycle strobe that flags a change of q. With WIDTH = 1 this is
// a plain D flip-flop with reset and complement.
//
// Optional feature, macro D_FF_EDGE_CNT_EN: when defined, the CNT_W
// parameter and the edge_cnt port exist. edge_cnt is a saturating count
// of q changes that only rst clears. When the macro is undefined, the
// port and the counter logic are absent.
//
// Parameters:
//   WIDTH     - data width of d, q and qbar
//   RESET_VAL - value loaded into q while rst is low
//   CNT_W     - width of edge_cnt (only with D_FF_EDGE_CNT_EN)
//
// Ports:
//   clk      - clock; all state updates on the rising edge
//   rst      - asynchronous, active-low reset
//   en       - clock enable for the d load path
//   sclr     - synchronous clear, q <= 0
//   sset     - synchronous set, q <= all ones
//   d        - data input
//   q        - registered data
//   qbar     - bitwise complement of q
//   changed  - registered strobe: q changed value at the last edge
//   edge_cnt - saturating count of q changes (only with D_FF_EDGE_CNT_EN)
module d_ff_reg #(
  parameter int unsigned      WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
`ifdef D_FF_EDGE_CNT_EN
  ,
  parameter int unsigned      CNT_W     = 8
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             sclr,
  input  logic             sset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar,
  output logic             changed
`ifdef D_FF_EDGE_CNT_EN
  ,
  output logic [CNT_W-1:0] edge_cnt
`endif
);

  logic [WIDTH-1:0] q_d, q_q;
  logic             changed_d, changed_q;

  // d only reaches q_d through the en branch, so an unknown d cannot
  // reach q while en, sclr and sset are all low.
  always_comb begin
    q_d = q_q;
    if (sclr) begin
      q_d = '0;
    end else if (sset) begin
      q_d = '1;
    end else if (en) begin
      q_d = d;
    end
    changed_d = (q_d != q_q);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_q       <= RESET_VAL;
      changed_q <= 1'b0;
    end else begin
      q_q       <= q_d;
      changed_q <= changed_d;
    end
  end

  assign q       = q_q;
  // Derived from q_q so it can never disagree with q, including during reset.
  assign qbar    = ~q_q;
  assign changed = changed_q;

`ifdef D_FF_EDGE_CNT_EN
  logic [CNT_W-1:0] cnt_d, cnt_q;

  // Holds at all ones instead of wrapping. sclr does not clear it.
  always_comb begin
    cnt_d = cnt_q;
    if (changed_d && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign edge_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_d_ff_reg.sv
// Directed self-checking bench for d_ff_reg (WIDTH = 1, RESET_VAL = 0).
// Inputs change on the falling edge; outputs are sampled on the falling
// edge, half a period after the rising edge that updated them.
module tb_d_ff_reg;

  logic clk;
  logic rst;
  logic en;
  logic sclr;
  logic sset;
  logic d;
  logic q;
  logic qbar;
  logic changed;
`ifdef D_FF_EDGE_CNT_EN
  logic [1:0] edge_cnt;
`endif

  int n_checks;
  int n_fail;

  d_ff_reg #(
    .WIDTH    (1),
    .RESET_VAL(1'b0)
`ifdef D_FF_EDGE_CNT_EN
    ,
    .CNT_W    (2)
`endif
  ) u_dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .sclr    (sclr),
    .sset    (sset),
    .d       (d),
    .q       (q),
    .qbar    (qbar),
    .changed (changed)
`ifdef D_FF_EDGE_CNT_EN
    ,
    .edge_cnt(edge_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 4-state compare, so an X on an output counts as a mismatch.
  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and return at the following falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Check q, qbar and changed together.
  task automatic check_out(input string tag, input logic exp_q, input logic exp_chg);
    check_eq({tag, "_q"}, {31'b0, q}, {31'b0, exp_q});
    check_eq({tag, "_qbar"}, {31'b0, qbar}, {31'b0, ~exp_q});
    check_eq({tag, "_chg"}, {31'b0, changed}, {31'b0, exp_chg});
  endtask

  logic       seq_d   [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
  logic       seq_chg [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
  logic [1:0] cnt_exp [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

  initial begin
    n_checks = 0;
    n_fail   = 0;

    // Reset asserted from t = 0 with d unknown.
    rst  = 1'b0;
    en   = 1'b0;
    sclr = 1'b0;
    sset = 1'b0;
    d    = 1'bx;
    #1;
    check_out("rst_t0", 1'b0, 1'b0);
`ifdef D_FF_EDGE_CNT_EN
    check_eq("rst_t0_cnt", {30'b0, edge_cnt}, 32'd0);
`endif
    tick();
    check_out("rst_e1", 1'b0, 1'b0);
    // Inputs must be ignored while reset is held.
    en   = 1'b1;
    sset = 1'b1;
    d    = 1'b1;
    tick();
    check_out("rst_e2", 1'b0, 1'b0);

    // Release reset; with no load enabled, q keeps RESET_VAL despite d = X.
    rst  = 1'b1;
    en   = 1'b0;
    sset = 1'b0;
    d    = 1'bx;
    tick();
    check_out("noload", 1'b0, 1'b0);

    // Load sequence 1,0,0,1.
    en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      d = seq_d[i];
      tick();
      check_out($sformatf("seq%0d", i), seq_d[i], seq_chg[i]);
    end

    // Enable low: q holds at 1 while d toggles.
    en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      d = i[0];
      tick();
      check_out($sformatf("hold%0d", i), 1'b1, 1'b0);
    end

    // sclr beats sset and en.
    sclr = 1'b1;
    sset = 1'b1;
    en   = 1'b1;
    d    = 1'b1;
    tick();
    check_out("prio_clr", 1'b0, 1'b1);
    // sset alone sets q.
    sclr = 1'b0;
    en   = 1'b0;
    d    = 1'b0;
    tick();
    check_out("sset", 1'b1, 1'b1);
    // Writing the value already held gives no strobe.
    tick();
    check_out("sset_same", 1'b1, 1'b0);
    sset = 1'b0;

    // Asynchronous reset between edges while q = 1.
    #2;
    rst = 1'b0;
    #1;
    check_out("async_rst", 1'b0, 1'b0);
`ifdef D_FF_EDGE_CNT_EN
    check_eq("async_rst_cnt", {30'b0, edge_cnt}, 32'd0);
`endif
    @(negedge clk);
    rst = 1'b1;
    tick();
    check_out("post_rst", 1'b0, 1'b0);

`ifdef D_FF_EDGE_CNT_EN
    // Five toggles of q: count saturates at 3.
    en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      d = ~i[0];
      tick();
      check_eq($sformatf("cnt%0d", i), {30'b0, edge_cnt}, {30'b0, cnt_exp[i]});
    end
    en = 1'b0;
    rst = 1'b0;
    #1;
    check_eq("cnt_rst", {30'b0, edge_cnt}, 32'd0);
    rst = 1'b1;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/d_ff_reg.md
Name: d_ff_reg

Overview:
- Parameterised D-type register with complementary outputs (q, qbar); default width 1 = single D flip-flop.
- Adds clock enable, synchronous clear/set and a one-cycle change-detect strobe.
- Used as a generic storage/pipeline element wherever the design needs a registered bit or vector with reset and complement.

Parameters:
- WIDTH, 1, data width of d, q, qbar.
- RESET_VAL, 0 (WIDTH bits), value loaded into q on reset; qbar resets to ~RESET_VAL.
- CNT_W, 8, width of edge_cnt; used only when D_FF_EDGE_CNT_EN is defined.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- en  input  1  clock enable for the d load path.
- sclr  input  1  synchronous clear (q <= 0).
- sset  input  1  synchronous set (q <= all ones).
- d  input  WIDTH  data input.
- q  output  WIDTH  registered data.
- qbar  output  WIDTH  bitwise complement of q.
- changed  output  1  registered strobe: q changed value at the last edge.
- edge_cnt  output  CNT_W  saturating count of q changes; present only with D_FF_EDGE_CNT_EN.

Behaviour:
- Reset:
  - rst low immediately, with no clock required: q=RESET_VAL, qbar=~RESET_VAL, changed=0, edge_cnt=0.
  - Reset held: outputs stay at their reset values, and d, en, sclr and sset are ignored.
  - rst release is synchronous to nothing. The first update occurs at the first rising clk edge with rst high.
- Per rising clk edge, with rst high, the priority is sclr > sset > en:
  - sclr=1: q <= 0.
  - else sset=1: q <= {WIDTH{1'b1}}.
  - else en=1: q <= d.
  - else: q holds.
- Latency: d is sampled at the edge and is visible on q after that edge. Single-cycle latency, no combinational path from d to q.
- qbar is always exactly ~q. It is either a separate register updated in the same cycle or driven as ~q. It must never differ from ~q at any sampled point, including during reset.
- changed:
  - Goes to 1 for exactly one cycle following an edge where the new q != old q.
  - Otherwise 0, including when sclr/sset/en write the same value q already holds.
- Reset mid-operation: takes effect asynchronously regardless of the clk phase or of a pending sclr/sset/en. changed and edge_cnt also clear.
- d is X or unknown before the first load: q stays RESET_VAL until a load actually occurs. No X may propagate to q while en, sclr and sset are all 0.

Optional Feature:
- Macro D_FF_EDGE_CNT_EN.
- Defined:
  - edge_cnt port exists.
  - Increments by 1 on every edge where changed would assert, i.e. where q takes a new value.
  - Saturates at 2^CNT_W-1 and does not wrap.
  - Cleared by rst only; sclr does not clear it.
- Undefined:
  - Port and counter logic are absent.
  - All other behaviour is identical.

Test Plan:
- rst=0 at t=0 with d=X, then rst=1 after 2 edges -> q=0, qbar=1, changed=0 throughout reset; q remains 0 until the first load.
- WIDTH=1, en=1, d sequence 1,0,0,1 on consecutive edges -> q follows one edge later (1,0,0,1); qbar=~q; changed pulses after edges 1, 2 and 4 only.
- en=0, d toggling 0/1 for 4 edges with q=1 -> q stays 1, changed=0.
- sclr=1 and sset=1 together with en=1, d=1 -> q=0 (sclr wins). Then sset=1 alone -> q=1, changed=1 for one cycle.
- Assert rst low between clk edges while q=1 -> q=0 and qbar=1 immediately, before the next edge.
- With D_FF_EDGE_CNT_EN, CNT_W=2: drive 5 toggles of q -> edge_cnt reads 1, 2, 3, 3, 3 (saturates). rst=0 -> edge_cnt=0.
